// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution operand sequencer.
// Imported by the loader top and its watchdog.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_STORE,
        ST_SWAIT,
        ST_RUN,
        ST_OUT
    } state_t;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_SA3    = 2'd1;
    localparam logic [1:0] MODE_SA2    = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    localparam int N_A   = 16;
    localparam int N_B   = 9;
    localparam int N_OPS = N_A + N_B;

endpackage

// File: rtl/conv_watchdog.sv
// Saturating cycle counter with clear/enable and an expiry flag.
// Expires on the TIMEOUT-th enabled cycle since the last clear.
module conv_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] r_cnt;

    // count enabled cycles, holding at TIMEOUT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != W'(TIMEOUT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_en && (r_cnt >= W'(TIMEOUT - 1));

endmodule

// File: rtl/conv_operand_loader.sv
// Loads a 25-byte A/B operand stream, drives the compute module
// through store and run requests, and returns the 2x2 result.
module conv_operand_loader
    import conv_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [1:0] mode,
    output logic [7:0] a11, a12, a13, a14,
    output logic [7:0] a21, a22, a23, a24,
    output logic [7:0] a31, a32, a33, a34,
    output logic [7:0] a41, a42, a43, a44,
    output logic [7:0] b11, b12, b13,
    output logic [7:0] b21, b22, b23,
    output logic [7:0] b31, b32, b33,
    output logic       active_store,
    output logic       active_single,
    output logic       active_sa3,
    output logic       active_sa2,
    input  logic       done_store,
    input  logic       done_single,
    input  logic       done_sa3,
    input  logic       done_sa2,
    input  logic [7:0] c11, c12, c21, c22,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] r11, r12, r21, r22,
    output logic       err
);

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_cnt;
    logic [1:0] r_mode;
    logic [7:0] r_ops [N_OPS];
    logic [7:0] r_res [4];
    logic       r_err;

    logic w_accept;
    logic w_last;
    logic w_capture;
    logic w_fail;
    logic w_release;
    logic w_done_sel;
    logic w_wd_en;
    logic w_expired;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == 5'(N_OPS - 1));
    assign w_wd_en  = (r_state == ST_SWAIT) || (r_state == ST_RUN);

    conv_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wd (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (!w_wd_en),
        .i_en     (w_wd_en),
        .o_expired(w_expired)
    );

    // completion flag belonging to the latched mode
    always_comb begin
        w_done_sel = 1'b0;
        unique case (r_mode)
            MODE_SINGLE: w_done_sel = done_single;
            MODE_SA3:    w_done_sel = done_sa3;
            MODE_SA2:    w_done_sel = done_sa2;
            MODE_RSVD:   w_done_sel = 1'b0;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_LOAD;
        else      r_state <= w_next;
    end

    // next state, handshake and request outputs
    always_comb begin
        w_next        = r_state;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        active_store  = 1'b0;
        active_single = 1'b0;
        active_sa3    = 1'b0;
        active_sa2    = 1'b0;
        w_capture     = 1'b0;
        w_fail        = 1'b0;
        w_release     = 1'b0;
        unique case (r_state)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && w_last) w_next = ST_STORE;
            end
            ST_STORE, ST_SWAIT: begin
                active_store = (r_state == ST_STORE);
                if (done_store) begin
                    // reserved mode never reaches the compute core
                    if (r_mode == MODE_RSVD) begin
                        w_next = ST_OUT;
                        w_fail = 1'b1;
                    end else begin
                        w_next = ST_RUN;
                    end
                end else if (r_state == ST_STORE) begin
                    w_next = ST_SWAIT;
                end else if (w_expired) begin
                    w_next = ST_OUT;
                    w_fail = 1'b1;
                end
            end
            ST_RUN: begin
                active_single = (r_mode == MODE_SINGLE);
                active_sa3    = (r_mode == MODE_SA3);
                active_sa2    = (r_mode == MODE_SA2);
                // a completion in the expiry cycle still counts
                if (w_done_sel) begin
                    w_next    = ST_OUT;
                    w_capture = 1'b1;
                end else if (w_expired) begin
                    w_next = ST_OUT;
                    w_fail = 1'b1;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next    = ST_LOAD;
                    w_release = 1'b1;
                end
            end
            default: w_next = ST_LOAD;
        endcase
    end

    // byte index and mode capture on stream acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_mode <= MODE_SINGLE;
        end else if (w_accept) begin
            r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
            if (r_cnt == 5'd0) r_mode <= mode;
        end
    end

    // operand register file written by stream index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_OPS; i++) r_ops[i] <= '0;
        end else if (w_accept) begin
            r_ops[r_cnt] <= in_data;
        end
    end

    // result capture, zeroed on any error exit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) r_res[i] <= '0;
        end else if (w_capture) begin
            r_res[0] <= c11;
            r_res[1] <= c12;
            r_res[2] <= c21;
            r_res[3] <= c22;
        end else if (w_fail) begin
            for (int i = 0; i < 4; i++) r_res[i] <= '0;
        end
    end

    // error flag qualifying the result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        r_err <= 1'b0;
        else if (w_fail)                 r_err <= 1'b1;
        else if (w_capture || w_release) r_err <= 1'b0;
    end

    assign a11 = r_ops[0];
    assign a12 = r_ops[1];
    assign a13 = r_ops[2];
    assign a14 = r_ops[3];
    assign a21 = r_ops[4];
    assign a22 = r_ops[5];
    assign a23 = r_ops[6];
    assign a24 = r_ops[7];
    assign a31 = r_ops[8];
    assign a32 = r_ops[9];
    assign a33 = r_ops[10];
    assign a34 = r_ops[11];
    assign a41 = r_ops[12];
    assign a42 = r_ops[13];
    assign a43 = r_ops[14];
    assign a44 = r_ops[15];
    assign b11 = r_ops[16];
    assign b12 = r_ops[17];
    assign b13 = r_ops[18];
    assign b21 = r_ops[19];
    assign b22 = r_ops[20];
    assign b23 = r_ops[21];
    assign b31 = r_ops[22];
    assign b32 = r_ops[23];
    assign b33 = r_ops[24];

    assign r11 = r_res[0];
    assign r12 = r_res[1];
    assign r21 = r_res[2];
    assign r22 = r_res[3];
    assign err = r_err;

endmodule

// File: tb/tb_conv_operand_loader.sv
// Directed bench for conv_operand_loader with a small compute stub.
// Vector table drives full runs; reset cases are hand-written.
module tb_conv_operand_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [1:0] mode = '0;
    logic [7:0] a11, a12, a13, a14, a21, a22, a23, a24;
    logic [7:0] a31, a32, a33, a34, a41, a42, a43, a44;
    logic [7:0] b11, b12, b13, b21, b22, b23, b31, b32, b33;
    logic       active_store, active_single, active_sa3, active_sa2;
    logic       done_store, done_single, done_sa3, done_sa2;
    logic [7:0] c11, c12, c21, c22;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] r11, r12, r21, r22;
    logic       err;

    always #5 clk = ~clk;

    conv_operand_loader #(.TIMEOUT(20)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mode(mode),
        .a11(a11), .a12(a12), .a13(a13), .a14(a14),
        .a21(a21), .a22(a22), .a23(a23), .a24(a24),
        .a31(a31), .a32(a32), .a33(a33), .a34(a34),
        .a41(a41), .a42(a42), .a43(a43), .a44(a44),
        .b11(b11), .b12(b12), .b13(b13),
        .b21(b21), .b22(b22), .b23(b23),
        .b31(b31), .b32(b32), .b33(b33),
        .active_store(active_store),
        .active_single(active_single),
        .active_sa3(active_sa3),
        .active_sa2(active_sa2),
        .done_store(done_store),
        .done_single(done_single),
        .done_sa3(done_sa3),
        .done_sa2(done_sa2),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .out_valid(out_valid), .out_ready(out_ready),
        .r11(r11), .r12(r12), .r21(r21), .r22(r22),
        .err(err)
    );

    // compute stub: valid 2x2 correlation of the operand pins
    logic [7:0] pa [16];
    logic [7:0] pb [9];
    logic [7:0] cres [4];
    always_comb begin
        int s;
        pa = '{a11, a12, a13, a14, a21, a22, a23, a24,
               a31, a32, a33, a34, a41, a42, a43, a44};
        pb = '{b11, b12, b13, b21, b22, b23, b31, b32, b33};
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += int'(pa[(r + i) * 4 + c + j])
                           * int'(pb[i * 3 + j]);
                cres[r * 2 + c] = s[7:0];
            end
        end
    end

    logic stub_hang = 1'b0;
    int   run_cnt;
    wire  act_any = active_single | active_sa3 | active_sa2;
    wire  dn_any  = done_single | done_sa3 | done_sa2;

    assign c11 = dn_any ? cres[0] : 8'hEE;
    assign c12 = dn_any ? cres[1] : 8'hEE;
    assign c21 = dn_any ? cres[2] : 8'hEE;
    assign c22 = dn_any ? cres[3] : 8'hEE;

    // stub handshake: store done next cycle, run done after 3 cycles
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_store  <= 1'b0;
            done_single <= 1'b0;
            done_sa3    <= 1'b0;
            done_sa2    <= 1'b0;
            run_cnt     <= 0;
        end else begin
            done_store <= active_store;
            if (act_any && !dn_any) begin
                if (run_cnt == 2) begin
                    run_cnt     <= 0;
                    done_single <= active_single && !stub_hang;
                    done_sa3    <= active_sa3 || (stub_hang && active_single);
                    done_sa2    <= active_sa2 || (stub_hang && active_single);
                end else begin
                    run_cnt <= run_cnt + 1;
                end
            end else begin
                done_single <= 1'b0;
                done_sa3    <= 1'b0;
                done_sa2    <= 1'b0;
                run_cnt     <= 0;
            end
        end
    end

    typedef struct {
        logic [1:0]  mode;
        int          set;
        bit          stall;
        bit          hang;
        bit          bp;
        logic [31:0] exp_r;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] ds [2][25];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int pins_diff(input int s);
        int d = 0;
        for (int k = 0; k < 16; k++) if (pa[k] !== ds[s][k]) d++;
        for (int k = 0; k < 9; k++) if (pb[k] !== ds[s][16 + k]) d++;
        return d;
    endfunction

    function automatic int pins_nonzero();
        int d = 0;
        for (int k = 0; k < 16; k++) if (pa[k] !== 8'd0) d++;
        for (int k = 0; k < 9; k++) if (pb[k] !== 8'd0) d++;
        return d;
    endfunction

    task automatic load_stream(input logic [1:0] m, input int s,
                               input bit stall);
        int sent = 0;
        int cyc  = 0;
        while (sent < 25 && cyc < 200) begin
            @(negedge clk);
            in_valid = stall ? cyc[0] : 1'b1;
            in_data  = ds[s][sent];
            mode     = (sent == 0) ? m : ~m;
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        chk("load_bytes", sent, 25);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int          t = 0;
        int          t_store = -1;
        int          t_out = -1;
        int          st_w = 0;
        int          rises = 0;
        int          extra = 0;
        bit          other = 0;
        bit          held = 1;
        bit          prev = 0;
        bit          sel, oth, dsel, stable;
        logic [31:0] snap;
        stub_hang = v.hang;
        out_ready = !v.bp;
        load_stream(v.mode, v.set, v.stall);
        while (t_out < 0 && t < 600) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'hA5;
            t++;
            if (in_ready) extra++;
            if (active_store) begin
                st_w++;
                if (t_store < 0) t_store = t;
            end
            unique case (v.mode)
                2'd0: begin
                    sel = active_single; dsel = done_single;
                    oth = active_sa3 | active_sa2;
                end
                2'd1: begin
                    sel = active_sa3; dsel = done_sa3;
                    oth = active_single | active_sa2;
                end
                2'd2: begin
                    sel = active_sa2; dsel = done_sa2;
                    oth = active_single | active_sa3;
                end
                default: begin
                    sel = 1'b0; dsel = 1'b0; oth = act_any;
                end
            endcase
            if (sel && !prev) rises++;
            prev = sel;
            if (oth) other = 1'b1;
            if (dsel && !sel) held = 1'b0;
            if (out_valid) t_out = t;
        end
        in_valid = 1'b0;
        $display("vector %0d: out after %0d cycles", id, t);
        chk("out_seen", (t_out > 0), 1);
        chk("extra_bytes", extra, 0);
        chk("store_width", st_w, 1);
        chk("req_pulse", {rises[7:0], other, held},
            {(v.mode == 2'd3) ? 8'd0 : 8'd1, 1'b0, 1'b1});
        chk("latency", t_out - t_store, v.exp_lat);
        chk("result", {r11, r12, r21, r22}, v.exp_r);
        chk("err", err, v.exp_err);
        chk("pins_hold", pins_diff(v.set), 0);
        if (v.bp) begin
            snap   = {r11, r12, r21, r22};
            stable = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (!out_valid || in_ready || err !== v.exp_err ||
                    {r11, r12, r21, r22} !== snap) stable = 1'b0;
            end
            chk("bp_hold", stable, 1);
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("release", {in_ready, out_valid, err}, 3'b100);
    endtask

    initial begin
        for (int k = 0; k < 25; k++) begin
            ds[0][k] = (k < 16) ? 8'((k % 4) + 1) : 8'((k - 16) / 3 + 1);
            ds[1][k] = (k < 16) ? 8'(k) :
                       (k == 16) ? 8'd1 : (k == 24) ? 8'd2 : 8'd0;
        end
        vecs[0] = '{2'd0, 0, 1'b0, 1'b0, 1'b0, 32'h24362436, 1'b0, 6};
        vecs[1] = '{2'd1, 0, 1'b1, 1'b0, 1'b0, 32'h24362436, 1'b0, 6};
        vecs[2] = '{2'd2, 0, 1'b1, 1'b0, 1'b1, 32'h24362436, 1'b0, 6};
        vecs[3] = '{2'd0, 1, 1'b0, 1'b0, 1'b0, 32'h14172023, 1'b0, 6};
        vecs[4] = '{2'd3, 0, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b1, 2};
        vecs[5] = '{2'd2, 1, 1'b1, 1'b0, 1'b0, 32'h14172023, 1'b0, 6};
        vecs[6] = '{2'd0, 0, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b1, 21};

        #7;
        chk("reset_ctl", {active_store, act_any, out_valid, err}, 0);
        chk("reset_res", {r11, r12, r21, r22}, 0);
        chk("reset_pins", pins_nonzero(), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", {in_ready, out_valid}, 2'b10);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // asynchronous reset while a run request is held
        stub_hang = 1'b0;
        out_ready = 1'b1;
        load_stream(2'd0, 1, 1'b0);
        for (int k = 0; k < 50 && !active_single; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("midrun_reached", active_single, 1);
        #2 rst = 1'b0;
        #1;
        chk("midrun_ctl", {active_store, act_any, out_valid, err}, 0);
        chk("midrun_pins", pins_nonzero(), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_ready", {in_ready, out_valid}, 2'b10);
        run_vec(vecs[3], 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_operand_loader.md
# conv_operand_loader

Upstream sequencer for `computation_module`. It accepts a 25-byte operand stream over a valid/ready handshake: the 4x4 input A row-major, then the 3x3 kernel B row-major. It holds the operands on the `a11..a44` / `b11..b33` pins and pulses `active_store`. It then holds the selected `active_*` mode request until the matching `done_*` arrives, captures `c11..c22`, and presents the 2x2 result downstream on a second valid/ready handshake.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent waiting for any `done_*` before aborting with error.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  `in_data` byte is valid.
- `in_ready`  out  1  block can accept a byte; high only in LOAD.
- `in_data`  in  8  operand byte, unsigned.
- `mode`  in  2  compute mode: 00 single, 01 sa3, 10 sa2, 11 reserved; sampled on acceptance of byte 0.
- `a11..a44`  out  8 each  registered A operands.
- `b11..b33`  out  8 each  registered B operands.
- `active_store`, `active_single`, `active_sa3`, `active_sa2`  out  1 each  requests to the compute module.
- `done_store`, `done_single`, `done_sa3`, `done_sa2`  in  1 each  completion flags from the compute module.
- `c11, c12, c21, c22`  in  8 each  compute results.
- `out_valid`  out  1  result registers are valid.
- `out_ready`  in  1  downstream accepts the result.
- `r11, r12, r21, r22`  out  8 each  captured results.
- `err`  out  1  qualifies `out_valid`; set on reserved mode or timeout.

## Operation
- **States:** LOAD, STORE, SWAIT, RUN, OUT.
- **LOAD:**
  - `in_ready`=1.
  - Each `in_valid & in_ready` writes `in_data` to operand index `cnt` (0-15 → `a11..a44` row-major, 16-24 → `b11..b33` row-major), then `cnt`++.
  - Byte 0 also latches `mode` into `mode_q`.
  - Accepting byte 24 moves to STORE and clears `cnt`.
- **STORE:** `active_store`=1 for exactly this one cycle, then SWAIT.
- **SWAIT:**
  - Waits for `done_store`=1, then enters RUN.
  - `done_store` sampled high during STORE also counts and skips SWAIT.
  - If `mode_q`=11, the block skips RUN and goes straight to OUT with `err`=1 and results 0.
- **RUN:**
  - The `active_*` selected by `mode_q` is held high every cycle in RUN.
  - When the matching `done_*` is sampled high, `c11..c22` are captured into `r11..r22`, the state moves to OUT, and `active_*` drops on the next cycle.
  - `done_*` flags of non-selected modes are ignored.
- **Watchdog:**
  - Counts cycles spent in SWAIT+RUN.
  - Reaching `TIMEOUT` goes to OUT with `err`=1 and `r11..r22`=0.
- **OUT:**
  - `out_valid`=1 with `r*` and `err` stable.
  - On `out_valid & out_ready`, the block returns to LOAD, clears `err`, and `in_ready` rises the next cycle.
- The operand outputs hold their last values until overwritten byte by byte during the next LOAD.

## Timing
- **Reset:**
  - All outputs are 0 while reset is low: operands, `r*`, `err`, `out_valid`, all `active_*`.
  - `in_ready` is 1 once out of reset (state LOAD).
  - `cnt`=0.
- **Reset mid-operation:** the current stream and result are discarded; nothing is retained.
- **Latency:**
  - Byte 24 accepted at edge N → `active_store` high in cycle N+1.
  - Minimum load-to-result latency is 25 + 1 + 1 + compute cycles + 1.
- **Handshakes:** data transfers only on an edge where valid and ready are both high. Gaps in `in_valid` stall `cnt` without loss.
- **Simultaneous events:**
  - `done_*` and watchdog expiry in the same cycle: done wins, `err`=0.
  - `out_ready` held high permanently gives a one-cycle OUT.
- **Widths:** `cnt` is 5 bits (0-24, never wraps past 24). The watchdog is `$clog2(TIMEOUT+1)` bits and saturates.

## Structure
- **Package `conv_pkg`:**
  - State enum.
  - Mode codes `MODE_SINGLE`=0, `MODE_SA3`=1, `MODE_SA2`=2, `MODE_RSVD`=3.
  - `N_A`=16, `N_B`=9, `N_OPS`=25.
- **Sub-module `conv_watchdog`:**
  - Clear/enable counter with an `expired` flag, parameterised by `TIMEOUT`.
  - Reusable by other sequencers.
- **Everything else in one module:** operand register file (25x8) written by index, FSM, and result capture.

## Test plan
- **Single mode, end to end:**
  - Stream A rows 1,2,3,4 (every row) and B rows 1,1,1 / 2,2,2 / 3,3,3 in mode 00 into `computation_module`.
  - Required: `active_store` is one cycle wide and `active_single` holds until `done_single`.
  - Required: `r11`=36, `r12`=54, `r21`=36, `r22`=54, `err`=0.
- **sa3 and sa2 with stalls:** same data in modes 01 and 10, with `in_valid` toggled every other cycle. Required: identical results, and exactly 25 bytes consumed per run.
- **Reserved mode:** mode 11 stream. Required: no `active_single/sa3/sa2` pulse, `out_valid` with `err`=1 and `r*`=0.
- **Watchdog:** stub that never raises `done_single`, `TIMEOUT`=20. Required: `out_valid` with `err`=1 exactly 20 cycles after entering SWAIT+RUN.
- **Back-pressure:** `out_ready` held low for 10 cycles. Required: `r*` and `out_valid` stable, `in_ready`=0. One cycle after `out_ready` rises, `in_ready`=1.
- **Reset mid-RUN:** drop `rst` during RUN. Required: all `active_*`=0 immediately (asynchronous). After release: LOAD with `cnt`=0, and a fresh 25-byte stream completes normally.
